// File: rtl/equiv_checker.sv
// Exhaustive equivalence sweeper: drives every WIDTH-bit vector, compares two responses.
// Optional EQUIV_CHECKER_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module equiv_checker #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] stim,
    input  logic             x_in,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_cnt,
    output logic [WIDTH-1:0] first_fail
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [7:0]       CNT_RELOAD = 8'(SETTLE - 1);
    localparam logic [7:0]       CNT_ONE    = 8'd1;
    localparam logic [WIDTH:0]   ERR_ONE    = (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] STIM_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] STIM_LAST  = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] stim_q, stim_d;
    logic [WIDTH:0]   err_q, err_d;
    logic [WIDTH-1:0] ff_q, ff_d;
    logic             pass_q, pass_d;
    logic             mismatch;
    logic             accept;
    logic             last_vec;

    assign mismatch = x_in ^ y_in;
    assign accept   = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
    assign last_vec = (stim_q == STIM_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stim_q  <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_SETTLE;
            S_SETTLE:       if (cnt_q == 8'd0) state_d = S_CHECK;
            S_CHECK: begin
`ifdef EQUIV_CHECKER_STOP_ON_FAIL_EN
                if (mismatch || last_vec) state_d = S_DONE;
                else                      state_d = S_SETTLE;
`else
                if (last_vec) state_d = S_DONE;
                else          state_d = S_SETTLE;
`endif
            end
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        stim_d = stim_q;
        err_d  = err_q;
        ff_d   = ff_q;
        pass_d = pass_q;
        if (accept) begin
            cnt_d  = CNT_RELOAD;
            stim_d = '0;
            err_d  = '0;
            ff_d   = '0;
            pass_d = 1'b0;
        end else if (state_q == S_SETTLE) begin
            if (cnt_q != 8'd0) cnt_d = cnt_q - CNT_ONE;
        end else if (state_q == S_CHECK) begin
            if (mismatch) begin
                err_d = err_q + ERR_ONE;
                if (err_q == '0) ff_d = stim_q;
            end
`ifdef EQUIV_CHECKER_STOP_ON_FAIL_EN
            // A failing vector freezes stim and leaves pass low.
            if (!mismatch) begin
                if (last_vec) begin
                    pass_d = (err_q == '0);
                end else begin
                    stim_d = stim_q + STIM_ONE;
                    cnt_d  = CNT_RELOAD;
                end
            end
`else
            if (last_vec) begin
                pass_d = (err_q == '0) && !mismatch;
            end else begin
                stim_d = stim_q + STIM_ONE;
                cnt_d  = CNT_RELOAD;
            end
`endif
        end
    end

    always_comb begin
        busy = (state_q == S_SETTLE) || (state_q == S_CHECK);
        done = (state_q == S_DONE);
    end

    assign stim       = stim_q;
    assign pass       = pass_q;
    assign err_cnt    = err_q;
    assign first_fail = ff_q;

endmodule
